// File: rtl/wb_dbg_master.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : wb_dbg_master
// Purpose  : Byte-stream to Wishbone master bridge. A host (typically behind
//            a UART byte core) sends framed commands; the bridge issues one
//            classic single 32-bit Wishbone read or write cycle and returns
//            a status byte, followed by four read-data bytes on a good read.
//
//            Command framing (multi-byte fields MSB first):
//              WRITE : 0x01 A3 A2 A1 A0 D3 D2 D1 D0  -> status
//              READ  : 0x02 A3 A2 A1 A0              -> status [D3 D2 D1 D0]
//            Status: 0x00 ack, 0x01 err, 0x02 rty, 0x03 bus timeout.
//
// Ports    : clk, reset            clock, synchronous active-high reset
//            rx_data/rx_valid      received byte + one-cycle strobe
//            tx_data/tx_valid/
//            tx_ready              response byte, valid/ready handshake
//            wb_*                  Wishbone classic master port
//            busy                  high whenever the bridge is not idle
//
// Revision : 1.0  initial release
// ============================================================================
module wb_dbg_master #(
  parameter int unsigned WB_TIMEOUT = 1024,    // 0 disables bus timeout
  parameter int unsigned RX_TIMEOUT = 1000000  // 0 disables inter-byte timeout
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_BUS   = 3'd3,
    S_STAT  = 3'd4,
    S_RDATA = 3'd5
  } state_t;

  localparam logic [7:0]  C_CMD_WRITE = 8'h01;
  localparam logic [7:0]  C_CMD_READ  = 8'h02;
  localparam logic [7:0]  C_ST_ACK    = 8'h00;
  localparam logic [7:0]  C_ST_ERR    = 8'h01;
  localparam logic [7:0]  C_ST_RTY    = 8'h02;
  localparam logic [7:0]  C_ST_TMO    = 8'h03;
  localparam logic [31:0] C_WB_LIMIT  = WB_TIMEOUT - 32'd1;
  localparam logic [31:0] C_RX_LIMIT  = RX_TIMEOUT - 32'd1;

  state_t      state_q;
  logic [1:0]  cnt_q;       // byte index within a 4-byte field
  logic        is_wr_q;     // command is a write
  logic [31:0] adr_q;
  logic [31:0] dat_q;       // write data, or captured read data
  logic [31:0] idle_q;      // idle cycles since last command byte
  logic [31:0] tmo_q;       // completed cycles of the current bus cycle
  logic        cyc_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;

  logic        w_rx_expired;
  logic        w_wb_expired;
  logic        w_term;

  // Timeout fires on the RX_TIMEOUT-th idle cycle / WB_TIMEOUT-th cyc cycle.
  assign w_rx_expired = (RX_TIMEOUT != 0) && (idle_q == C_RX_LIMIT);
  assign w_wb_expired = (WB_TIMEOUT != 0) && (tmo_q == C_WB_LIMIT);
  assign w_term       = wb_ack_i || wb_err_i || wb_rty_i || w_wb_expired;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      is_wr_q    <= 1'b0;
      adr_q      <= 32'd0;
      dat_q      <= 32'd0;
      idle_q     <= 32'd0;
      tmo_q      <= 32'd0;
      cyc_q      <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Unknown opcodes are dropped without leaving IDLE.
          if (rx_valid && (rx_data == C_CMD_WRITE || rx_data == C_CMD_READ)) begin
            is_wr_q <= (rx_data == C_CMD_WRITE);
            cnt_q   <= 2'd0;
            idle_q  <= 32'd0;
            state_q <= S_ADDR;
          end
        end

        S_ADDR, S_WDATA: begin
          if (rx_valid) begin
            idle_q <= 32'd0;
            cnt_q  <= cnt_q + 2'd1;  // wraps to 0 ready for the data field
            if (state_q == S_ADDR) begin
              adr_q <= {adr_q[23:0], rx_data};
            end else begin
              dat_q <= {dat_q[23:0], rx_data};
            end
            if (cnt_q == 2'd3) begin
              if (state_q == S_ADDR && is_wr_q) begin
                state_q <= S_WDATA;
              end else begin
                state_q <= S_BUS;
                cyc_q   <= 1'b1;
                tmo_q   <= 32'd0;
              end
            end
          end else if (w_rx_expired) begin
            // Host went silent mid-command: resync, no bus cycle, no reply.
            state_q <= S_IDLE;
          end else begin
            idle_q <= idle_q + 32'd1;
          end
        end

        S_BUS: begin
          if (w_term) begin
            cyc_q      <= 1'b0;
            tx_valid_q <= 1'b1;
            state_q    <= S_STAT;
            // Priority ack > err > rty > timeout, so a late ack still wins.
            if (wb_ack_i) begin
              tx_data_q <= C_ST_ACK;
              if (!is_wr_q) begin
                dat_q <= wb_dat_i;
              end
            end else if (wb_err_i) begin
              tx_data_q <= C_ST_ERR;
            end else if (wb_rty_i) begin
              tx_data_q <= C_ST_RTY;
            end else begin
              tx_data_q <= C_ST_TMO;
            end
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end

        S_STAT: begin
          if (tx_ready) begin
            if (!is_wr_q && tx_data_q == C_ST_ACK) begin
              tx_data_q <= dat_q[31:24];
              cnt_q     <= 2'd0;
              state_q   <= S_RDATA;
            end else begin
              tx_valid_q <= 1'b0;
              state_q    <= S_IDLE;
            end
          end
        end

        S_RDATA: begin
          // cnt_q is the index of the data byte currently presented.
          if (tx_ready) begin
            cnt_q <= cnt_q + 2'd1;
            case (cnt_q)
              2'd0: tx_data_q <= dat_q[23:16];
              2'd1: tx_data_q <= dat_q[15:8];
              2'd2: tx_data_q <= dat_q[7:0];
              default: begin
                tx_valid_q <= 1'b0;
                state_q    <= S_IDLE;
              end
            endcase
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_sel_o = {4{cyc_q}};
  assign wb_we_o  = cyc_q & is_wr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wb_dbg_master.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_dbg_master
// Purpose  : Self-checking bench for wb_dbg_master. Expected bus activity and
//            response bytes are derived from the command values and the
//            chosen slave behaviour (latency / termination kind).
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_dbg_master;

  localparam int unsigned WB_TMO = 16;
  localparam int unsigned RX_TMO = 100;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  wb_dbg_master #(
    .WB_TIMEOUT (WB_TMO),
    .RX_TIMEOUT (RX_TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .wb_rty_i (wb_rty_i),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    chk({tag, "_tx_data"},  {24'd0, tx_data},  32'd0);
    chk({tag, "_adr"},      wb_adr_o,          32'd0);
    chk({tag, "_dat"},      wb_dat_o,          32'd0);
    chk({tag, "_cyc_stb"},  {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk({tag, "_sel_we"},   {27'd0, wb_sel_o, wb_we_o},  32'd0);
    chk({tag, "_busy"},     {31'd0, busy},     32'd0);
  endtask

  // Bytes go out on negedges with small random gaps (well under RX_TMO).
  task automatic send_bytes(input bq_t b);
    foreach (b[i]) begin
      if (i > 0) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          rx_valid = 1'b0;
        end
      end
      @(negedge clk);
      rx_data  = b[i];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  function automatic bq_t cmd_bytes(input bit is_wr, input logic [31:0] adr, input logic [31:0] dat);
    bq_t q;
    q = {};
    q.push_back(is_wr ? 8'h01 : 8'h02);
    for (int i = 3; i >= 0; i--) q.push_back(adr[8*i +: 8]);
    if (is_wr) for (int i = 3; i >= 0; i--) q.push_back(dat[8*i +: 8]);
    return q;
  endfunction

  // kind: 0 ack, 1 err, 2 rty, 3 slave silent. Slave terminates during the
  // (lat+1)-th cycle of cyc high. rmode: 0 random tx_ready, 1 toggling 1-0-1.
  task automatic do_cmd(input bit is_wr, input logic [31:0] adr, input logic [31:0] dat,
                        input int kind, input int lat, input bit rmode);
    bq_t  expq;
    int   hi, bad, guard, got, unstable, tick, exp_hi, exp_st;
    bit   terminated, prev_v;
    logic [7:0] prev;

    terminated = (kind != 3) && (lat + 1 <= int'(WB_TMO));
    exp_hi     = terminated ? lat + 1 : int'(WB_TMO);
    exp_st     = terminated ? kind : 3;

    send_bytes(cmd_bytes(is_wr, adr, dat));
    wb_dat_i = dat;
    chk("cyc_start", {31'd0, wb_cyc_o}, 32'd1);

    hi = 0; bad = 0; guard = 0;
    while (wb_cyc_o === 1'b1 && guard < 100) begin
      hi++;
      if (wb_adr_o !== adr || wb_stb_o !== 1'b1 || wb_sel_o !== 4'hF ||
          wb_we_o !== is_wr || (is_wr && wb_dat_o !== dat)) bad++;
      wb_ack_i = (kind == 0) && (hi == lat + 1);
      wb_err_i = (kind == 1) && (hi == lat + 1);
      wb_rty_i = (kind == 2) && (hi == lat + 1);
      rx_valid = (hi == 1);          // stray byte during the bus cycle
      rx_data  = 8'($urandom);
      @(negedge clk);
      rx_valid = 1'b0;
      guard++;
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    chk("bus_signals", bad, 0);
    chk("cyc_cycles", hi, exp_hi);
    chk("bus_idle_after", {26'd0, wb_sel_o, wb_we_o, wb_stb_o}, 32'd0);

    expq = {};
    expq.push_back(8'(exp_st));
    if (!is_wr && exp_st == 0) for (int i = 3; i >= 0; i--) expq.push_back(dat[8*i +: 8]);

    chk("tx_valid_first", {31'd0, tx_valid}, 32'd1);
    chk("busy_resp", {31'd0, busy}, 32'd1);

    got = 0; guard = 0; prev_v = 1'b0; prev = 8'd0; unstable = 0; tick = 0;
    while (got < expq.size() && guard < 200) begin
      if (prev_v && (tx_valid !== 1'b1 || tx_data !== prev)) unstable++;
      tx_ready = rmode ? (tick % 2 == 0) : 1'($urandom_range(0, 1));
      if (tx_valid === 1'b1 && tx_ready) begin
        chk($sformatf("tx_byte%0d", got), {24'd0, tx_data}, {24'd0, expq[got]});
        got++;
        prev_v = 1'b0;
      end else begin
        prev_v = (tx_valid === 1'b1);
        prev   = tx_data;
      end
      tick++;
      @(negedge clk);
      guard++;
    end
    tx_ready = 1'b0;
    chk("tx_count", got, expq.size());
    chk("tx_hold_stable", unstable, 0);
    chk("tx_valid_end", {31'd0, tx_valid}, 32'd0);
    chk("busy_end", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc_seen;
    reset = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; tx_ready = 1'b0;
    wb_dat_i = 32'd0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_idle_zero("reset");

    // Directed write with ack after 2 wait cycles.
    do_cmd(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 0, 2, 1'b0);
    // Directed read, tx_ready toggling.
    do_cmd(1'b0, 32'h7000_0004, 32'h1234_5678, 0, 1, 1'b1);
    // Error then retry terminations.
    do_cmd(1'b0, $urandom, $urandom, 1, 0, 1'b0);
    do_cmd(1'b0, $urandom, $urandom, 2, 3, 1'b0);
    // Bus timeout, then ack coinciding with the last allowed cycle.
    do_cmd(1'b0, $urandom, $urandom, 3, 0, 1'b0);
    do_cmd(1'b0, 32'h0000_0100, 32'hCAFE_F00D, 0, 15, 1'b1);

    // Partial command followed by silence: must resync with no bus cycle.
    send_bytes('{8'h02, 8'h70, 8'h00});
    cyc_seen = 0;
    repeat (150) begin
      if (wb_cyc_o !== 1'b0 || tx_valid !== 1'b0) cyc_seen++;
      @(negedge clk);
    end
    chk("partial_no_cycle", cyc_seen, 0);
    chk("partial_busy", {31'd0, busy}, 32'd0);
    do_cmd(1'b0, 32'h7000_0008, 32'hA5A5_0FF0, 0, 0, 1'b0);

    // Stray non-command byte in IDLE.
    send_bytes('{8'h55});
    chk("stray_busy", {31'd0, busy}, 32'd0);
    do_cmd(1'b1, 32'h0000_0055, 32'h0102_0304, 0, 0, 1'b0);

    // Reset while cyc is high.
    send_bytes(cmd_bytes(1'b1, 32'h1111_2222, 32'h3333_4444));
    repeat (3) @(negedge clk);
    chk("pre_reset_cyc", {31'd0, wb_cyc_o}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_idle_zero("rst_cyc");
    reset = 1'b0;
    do_cmd(1'b0, 32'h2000_0000, 32'h8765_4321, 0, 1, 1'b0);

    // Reset while a response byte is pending.
    send_bytes(cmd_bytes(1'b0, 32'h5555_0000, 32'h0));
    wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    chk("pre_reset_txv", {31'd0, tx_valid}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_idle_zero("rst_tx");
    reset = 1'b0;
    do_cmd(1'b1, 32'hFFFF_FFFC, 32'h0BAD_CAFE, 0, 4, 1'b1);

    // Randomized transactions.
    for (int n = 0; n < 24; n++) begin
      do_cmd(1'($urandom_range(0, 1)), $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 17)),
             1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
